// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank clock-enable generator.
//   DIV_OFF    : divisor value that switches a channel off
//   CNT_W_MAX  : widest supported divisor/counter (CNT_W must not exceed it)
//   chan_cfg_t : per-channel divisor state (active, pending, pending flag)
//   ch_w()     : channel-select width, $clog2(n) with a floor of 1
package clk_div_pkg;

   localparam int unsigned DIV_OFF   = 0;
   localparam int unsigned CNT_W_MAX = 32;

   typedef struct packed {
      logic [CNT_W_MAX-1:0] div;
      logic [CNT_W_MAX-1:0] pend_div;
      logic                 pending;
   } chan_cfg_t;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable clock-enable channel: divisor, counter, tick and clk_out.
// Build option: CLK_DIV_GLITCHFREE_EN defers a divisor write on a running
// channel to its next terminal count so no clk_out half-period is cut short.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   wr, wdiv      : accepted divisor write and its value (0 = off)
//   sync          : phase-align request shared by all channels
//   tick          : one-cycle enable strobe every div cycles
//   clk_out       : 50% square wave, period 2*div
//   busy          : a deferred write is waiting for the terminal count
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 24,
   parameter int unsigned DEF_DIV = 27000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [CNT_W-1:0] wdiv,
   input  logic             sync,
   output logic             tick,
   output logic             clk_out,
   output logic             busy
);

   logic [CNT_W-1:0] cnt_q;
   logic             div_zero;
   logic             term;

`ifdef CLK_DIV_GLITCHFREE_EN
   chan_cfg_t              cfg_q;
   logic [CNT_W_MAX-1:0]   wdiv_ext;
   logic                   pend_zero;

   assign wdiv_ext  = CNT_W_MAX'(wdiv);
   assign div_zero  = (cfg_q.div == CNT_W_MAX'(DIV_OFF));
   assign pend_zero = (cfg_q.pend_div == CNT_W_MAX'(DIV_OFF));
   assign term      = (cnt_q == CNT_W'(cfg_q.div - CNT_W_MAX'(1)));
   assign busy      = cfg_q.pending;

   // Divisor state: off channels and sync take writes at once, running
   // channels park the write until the terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q.div      <= CNT_W_MAX'(DEF_DIV);
         cfg_q.pend_div <= CNT_W_MAX'(DIV_OFF);
         cfg_q.pending  <= 1'b0;
      end else if (sync) begin
         if (wr)
            cfg_q.div <= wdiv_ext;
         else if (cfg_q.pending)
            cfg_q.div <= cfg_q.pend_div;
         cfg_q.pending <= 1'b0;
      end else if (div_zero) begin
         if (wr)
            cfg_q.div <= wdiv_ext;
      end else begin
         if (term && cfg_q.pending) begin
            cfg_q.div     <= cfg_q.pend_div;
            cfg_q.pending <= 1'b0;
         end
         if (wr) begin
            cfg_q.pend_div <= wdiv_ext;
            cfg_q.pending  <= 1'b1;
         end
      end
   end
`else
   logic [CNT_W-1:0] div_q;

   assign div_zero = (div_q == CNT_W'(DIV_OFF));
   assign term     = (cnt_q == div_q - CNT_W'(1));
   assign busy     = 1'b0;

   // Divisor register: every accepted write lands immediately.
   always_ff @(posedge clk) begin
      if (rst)
         div_q <= CNT_W'(DEF_DIV);
      else if (wr)
         div_q <= wdiv;
   end
`endif

   // Counter and output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else if (sync || div_zero) begin
         cnt_q   <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         if (term) begin
            cnt_q   <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
         end
`ifdef CLK_DIV_GLITCHFREE_EN
         // A deferred divisor of zero parks the wave low as the last tick fires.
         if (term && cfg_q.pending && pend_zero)
            clk_out <= 1'b0;
`else
         // Restart the count from the write; switching off parks the wave low.
         if (wr) begin
            cnt_q <= '0;
            if (wdiv == CNT_W'(DIV_OFF)) begin
               tick    <= 1'b0;
               clk_out <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock-enable channels.
// Build option: CLK_DIV_GLITCHFREE_EN (deferred, glitch-free divisor writes).
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   cfg_valid/ready   : divisor write handshake (ready is combinational)
//   cfg_ch, cfg_div   : target channel (out-of-range writes are dropped), divisor
//   sync              : phase-align every channel
//   tick, clk_out     : per-channel enable strobe and square wave
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH  = 4,
   parameter  int unsigned CNT_W   = 24,
   parameter  int unsigned DEF_DIV = 27000,
   localparam int unsigned CH_W    = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              sync,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out
);

   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] wr;
   logic              accept;

   // Ready mux: out-of-range channels always accept (and discard).
   always_comb begin
      cfg_ready = 1'b1;
      if (32'(cfg_ch) < NUM_CH)
         cfg_ready = ~busy[cfg_ch];
   end

   assign accept = cfg_valid && cfg_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr[i] = accept && (cfg_ch == CH_W'(i));

      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr[i]),
         .wdiv    (cfg_div),
         .sync    (sync),
         .tick    (tick[i]),
         .clk_out (clk_out[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: a 4-channel and a 3-channel instance
// share stimulus; a countdown model of each channel is compared every cycle.
module tb_clk_div_bank;

   localparam int unsigned DEF = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       sync = 1'b0;
   logic [1:0] cfg_ch = 2'd0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ready, cfg_ready3;
   logic [3:0] tick, clk_out;
   logic [2:0] tick3, clk_out3;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   clk_div_bank #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(DEF)) u_dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync(sync),
      .tick(tick), .clk_out(clk_out));

   clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(DEF)) u_dut3 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync(sync),
      .tick(tick3), .clk_out(clk_out3));

   initial forever #5 clk = ~clk;

   // Model: per channel, edges left until the next tick.
   int m_div  [2][4];
   int m_left [2][4];
   int m_pdiv [2][4];
   bit m_tick [2][4];
   bit m_clk  [2][4];
   bit m_pend [2][4];

   function automatic int nch(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic bit mdl_ready(input int d);
      if (int'(cfg_ch) >= nch(d)) return 1'b1;
`ifdef CLK_DIV_GLITCHFREE_EN
      return !m_pend[d][cfg_ch];
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit rdy [2];
      for (int d = 0; d < 2; d++) rdy[d] = mdl_ready(d);
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < nch(d); c++) begin
            bit wr;
            bit term;
            wr = cfg_valid && rdy[d] && (int'(cfg_ch) == c);
            if (rst) begin
               m_div[d][c] = DEF; m_left[d][c] = DEF;
               m_tick[d][c] = 0; m_clk[d][c] = 0; m_pend[d][c] = 0;
            end else if (sync) begin
               m_tick[d][c] = 0; m_clk[d][c] = 0;
               if (m_pend[d][c]) m_div[d][c] = m_pdiv[d][c];
               m_pend[d][c] = 0;
               if (wr) m_div[d][c] = int'(cfg_div);
               m_left[d][c] = m_div[d][c];
            end else if (m_div[d][c] == 0) begin
               if (wr) begin m_div[d][c] = int'(cfg_div); m_left[d][c] = m_div[d][c]; end
               m_tick[d][c] = 0; m_clk[d][c] = 0;
            end else begin
               term = (m_left[d][c] == 1);
               m_left[d][c] = m_left[d][c] - 1;
               if (term) begin
                  m_tick[d][c] = 1; m_clk[d][c] = !m_clk[d][c]; m_left[d][c] = m_div[d][c];
               end else begin
                  m_tick[d][c] = 0;
               end
`ifdef CLK_DIV_GLITCHFREE_EN
               if (term && m_pend[d][c]) begin
                  m_div[d][c] = m_pdiv[d][c]; m_pend[d][c] = 0; m_left[d][c] = m_div[d][c];
                  if (m_div[d][c] == 0) m_clk[d][c] = 0;
               end
               if (wr) begin m_pend[d][c] = 1; m_pdiv[d][c] = int'(cfg_div); end
`else
               if (wr) begin
                  m_div[d][c] = int'(cfg_div); m_left[d][c] = m_div[d][c];
                  if (m_div[d][c] == 0) begin m_tick[d][c] = 0; m_clk[d][c] = 0; end
               end
`endif
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (checking) begin
         for (int d = 0; d < 2; d++) begin
            logic [3:0] et, ec;
            et = '0; ec = '0;
            for (int c = 0; c < nch(d); c++) begin
               et[c] = m_tick[d][c];
               ec[c] = m_clk[d][c];
            end
            if (d == 0) begin
               chk("tick4", 32'(tick), 32'(et));
               chk("clk_out4", 32'(clk_out), 32'(ec));
               chk("cfg_ready4", 32'(cfg_ready), 32'(mdl_ready(0)));
            end else begin
               chk("tick3", 32'(tick3), 32'(et));
               chk("clk_out3", 32'(clk_out3), 32'(ec));
               chk("cfg_ready3", 32'(cfg_ready3), 32'(mdl_ready(1)));
            end
         end
      end
   end

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wait_n;
      // Reset and default divisor, then one divisor change.
      next_edge(); next_edge();
      checking = 1'b1;
      @(negedge clk);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_clk_out", 32'(clk_out), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h1);
      next_edge(); rst = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         next_edge();
         cfg_valid = (e == 9);
`ifdef CLK_DIV_GLITCHFREE_EN
         if (e == 9)  begin cfg_ch = 2'd2; cfg_div = 8'd10; end
         if (e == 10) cfg_ch = 2'd2;
         if (e == 11) cfg_ch = 2'd0;
         if (e == 12) cfg_ch = 2'd2;
`else
         if (e == 9) begin cfg_ch = 2'd1; cfg_div = 8'd3; end
`endif
         @(negedge clk);
         chk("lit_tick0", 32'(tick[0]), 32'(e % 4 == 0));
         if (e <= 9)
            chk("lit_clk_out", 32'(clk_out), (e >= 4 && e < 8) ? 32'hF : 32'h0);
`ifdef CLK_DIV_GLITCHFREE_EN
         chk("lit_gf_tick2", 32'(tick[2]),
             (e <= 12) ? 32'(e % 4 == 0) : 32'((e - 12) % 10 == 0));
         if (e >= 10 && e <= 12)
            chk("lit_gf_ready", 32'(cfg_ready), (e == 10) ? 32'h0 : 32'h1);
`else
         chk("lit_imm_tick1", 32'(tick[1]),
             (e <= 9) ? 32'(e % 4 == 0) : 32'(e > 10 && (e - 10) % 3 == 0));
`endif
      end

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         next_edge();
         rst       = ($urandom_range(0, 399) == 0);
         sync      = ($urandom_range(0, 79) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       cfg_div = 8'd0;
            1:       cfg_div = 8'd1;
            2:       cfg_div = 8'd2;
            default: cfg_div = 8'($urandom_range(3, 12));
         endcase
      end
      next_edge();
      rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0;

      // Divisors 5/5/7/7 with random phase, then sync.
      sync = 1'b1;
      next_edge(); sync = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_div = (c < 2) ? 8'd5 : 8'd7;
         next_edge();
      end
      cfg_valid = 1'b0;
      wait_n = int'($urandom_range(0, 7));
      repeat (wait_n) next_edge();
      sync = 1'b1;
      next_edge(); sync = 1'b0;
      @(negedge clk);
      chk("sync_tick", 32'(tick), 32'h0);
      chk("sync_clk_out", 32'(clk_out), 32'h0);
      for (int e = 1; e <= 14; e++) begin
         logic [3:0] et, ec;
         next_edge();
         @(negedge clk);
         et = {(e % 7 == 0), (e % 7 == 0), (e % 5 == 0), (e % 5 == 0)};
         ec = {((e / 7) % 2 == 1), ((e / 7) % 2 == 1), ((e / 5) % 2 == 1), ((e / 5) % 2 == 1)};
         chk("lit_sync_tick", 32'(tick), 32'(et));
         chk("lit_sync_clk_out", 32'(clk_out), 32'(ec));
      end

      // Channel 3 off, then divisor 1.
      next_edge();
      sync = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
      next_edge(); sync = 1'b0; cfg_valid = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         next_edge();
         @(negedge clk);
         chk("lit_off_tick3", 32'(tick[3]), 32'h0);
         chk("lit_off_clk3", 32'(clk_out[3]), 32'h0);
      end
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1;
      next_edge(); cfg_valid = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         next_edge();
         @(negedge clk);
         chk("lit_div1_tick3", 32'(tick[3]), 32'h1);
         chk("lit_div1_clk3", 32'(clk_out[3]), 32'(e % 2));
      end

      // Reset while a write is outstanding; out-of-range write on 3-ch bank.
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9;
      next_edge(); cfg_valid = 1'b0; rst = 1'b1;
      next_edge(); rst = 1'b0; cfg_ch = 2'd0;
      @(negedge clk);
      chk("rst2_tick", 32'(tick), 32'h0);
      chk("rst2_clk_out", 32'(clk_out), 32'h0);
      chk("rst2_ready", 32'(cfg_ready), 32'h1);
      for (int e = 1; e <= 8; e++) begin
         next_edge();
         cfg_valid = (e == 1); cfg_ch = 2'd3; cfg_div = 8'd2;
         @(negedge clk);
         if (e == 1) chk("oor_ready3", 32'(cfg_ready3), 32'h1);
         chk("rst2_lit_tick", 32'(tick[2:0]), (e % 4 == 0) ? 32'h7 : 32'h0);
         chk("oor_tick3", 32'(tick3), (e % 4 == 0) ? 32'h7 : 32'h0);
         chk("oor_clk_out3", 32'(clk_out3), (e >= 4 && e < 8) ? 32'h7 : 32'h0);
      end
      cfg_valid = 1'b0;
      next_edge();

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
